alu16: RTL and testbench

- 16-bit arithmetic/logic unit for the 5-stage pipelined CPU's EX stage.
- Computes a result and three condition flags (CF, ZF, NF) from a 4-bit operation code and two 16-bit operands.
- Combinational outputs feed the EX/MEM pipeline registers directly.
- A registered copy of result and flags, updated under a load enable, is also provided for debug/observation.

---
 rtl/alu16_pkg.sv | 25 ++
 rtl/alu16_if.sv | 16 +
 rtl/alu16_shifter.sv | 30 +++
 rtl/alu16.sv | 79 +++++++
 tb/tb_alu16.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/alu16_pkg.sv
// Shared ALU constants: opcode encoding, flag bit positions and shifter modes.
// The CPU control logic imports the same opcode values.
package alu16_pkg;
  localparam logic [3:0] A_ADD    = 4'd0;
  localparam logic [3:0] A_ADDPLS = 4'd1;
  localparam logic [3:0] A_SUB    = 4'd2;
  localparam logic [3:0] A_SUBMNS = 4'd3;
  localparam logic [3:0] A_AND    = 4'd4;
  localparam logic [3:0] A_OR     = 4'd5;
  localparam logic [3:0] A_XOR    = 4'd6;
  localparam logic [3:0] A_NOT    = 4'd7;
  localparam logic [3:0] A_SL     = 4'd8;
  localparam logic [3:0] A_SRL    = 4'd9;
  localparam logic [3:0] A_SRA    = 4'd10;

  localparam int CF_BIT = 0;
  localparam int ZF_BIT = 1;
  localparam int NF_BIT = 2;

  typedef enum logic [1:0] {
    SH_L  = 2'd0,
    SH_RL = 2'd1,
    SH_RA = 2'd2
  } shift_e;
endpackage

// File: rtl/alu16_if.sv
// EX-stage ALU bus: operation request from the pipeline, result/flags back.
interface alu16_if #(parameter int WIDTH = 16);
  logic [3:0]       opcode;
  logic [WIDTH-1:0] operandA;
  logic [WIDTH-1:0] operandB;
  logic             load;
  logic [WIDTH-1:0] ALUo;
  logic [2:0]       flags;
  logic [WIDTH-1:0] ALUo_q;
  logic [2:0]       flags_q;

  modport master (output opcode, operandA, operandB, load,
                  input  ALUo, flags, ALUo_q, flags_q);
  modport slave  (input  opcode, operandA, operandB, load,
                  output ALUo, flags, ALUo_q, flags_q);
endinterface

// File: rtl/alu16_shifter.sv
// Barrel shifter for SL/SRL/SRA; co_o is the last bit shifted out (0 when n=0).
module alu16_shifter
  import alu16_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [SHW-1:0]   n_i,
  input  shift_e           mode_i,
  output logic [WIDTH-1:0] y_o,
  output logic             co_o
);
  // One guard bit past each end catches the shifted-out bit for free.
  logic [WIDTH:0] l_ext;
  logic [WIDTH:0] r_ext;

  always_comb begin
    l_ext = {1'b0, a_i} << n_i;
    if (mode_i == SH_RA) r_ext = $signed({a_i, 1'b0}) >>> n_i;
    else                 r_ext = {a_i, 1'b0} >> n_i;

    y_o  = l_ext[WIDTH-1:0];
    co_o = l_ext[WIDTH];
    if (mode_i != SH_L) begin
      y_o  = r_ext[WIDTH:1];
      co_o = r_ext[0];
    end
  end
endmodule

// File: rtl/alu16.sv
// 16-bit EX-stage ALU: combinational result/flags plus a load-enabled
// registered copy for observation.
module alu16
  import alu16_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic   clock,
  input logic   reset_n,
  alu16_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH:0]   sum, diff;
  logic             cin, bin;
  logic [WIDTH-1:0] sh_y;
  logic             sh_co;
  shift_e           sh_mode;
  logic [WIDTH-1:0] res_d, res_q;
  logic [2:0]       flg_d, flg_q;
  logic             cf, rsvd;

  alu16_shifter #(.WIDTH(WIDTH)) u_shift (
    .a_i   (bus.operandA),
    .n_i   (bus.operandB[SHW-1:0]),
    .mode_i(sh_mode),
    .y_o   (sh_y),
    .co_o  (sh_co)
  );

  // Bit WIDTH of diff is the unsigned borrow.
  always_comb begin
    cin  = (bus.opcode == A_ADDPLS);
    bin  = (bus.opcode == A_SUBMNS);
    sum  = {1'b0, bus.operandA} + {1'b0, bus.operandB} + (WIDTH+1)'(cin);
    diff = {1'b0, bus.operandA} - {1'b0, bus.operandB} - (WIDTH+1)'(bin);

    sh_mode = SH_L;
    if (bus.opcode == A_SRL) sh_mode = SH_RL;
    if (bus.opcode == A_SRA) sh_mode = SH_RA;

    res_d = '0;
    cf    = 1'b0;
    rsvd  = 1'b0;
    case (bus.opcode)
      A_ADD, A_ADDPLS:    {cf, res_d} = sum;
      A_SUB, A_SUBMNS:    {cf, res_d} = diff;
      A_AND:              res_d = bus.operandA & bus.operandB;
      A_OR:               res_d = bus.operandA | bus.operandB;
      A_XOR:              res_d = bus.operandA ^ bus.operandB;
      A_NOT:              res_d = ~bus.operandA;
      A_SL, A_SRL, A_SRA: begin
        res_d = sh_y;
        cf    = sh_co;
      end
      default:            rsvd = 1'b1;
    endcase

    flg_d         = '0;
    flg_d[CF_BIT] = cf;
    flg_d[ZF_BIT] = rsvd | (res_d == '0);
    flg_d[NF_BIT] = ~rsvd & res_d[WIDTH-1];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      res_q <= '0;
      flg_q <= '0;
    end else if (bus.load) begin
      res_q <= res_d;
      flg_q <= flg_d;
    end
  end

  assign bus.ALUo    = res_d;
  assign bus.flags   = flg_d;
  assign bus.ALUo_q  = res_q;
  assign bus.flags_q = flg_q;
endmodule

// File: tb/tb_alu16.sv
// Self-checking bench for alu16: directed vector table, random ops against an
// integer reference model, and hand-written sequences for the registered path.
module tb_alu16;
  import alu16_pkg::*;

  logic clock;
  logic reset_n;
  int   checks;
  int   errors;

  alu16_if #(.WIDTH(16)) bus ();
  alu16 #(.WIDTH(16)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic [2:0]  flg;   // {NF,ZF,CF}
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference model from the arithmetic rules, using plain integers.
  function automatic void model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] r, output logic [2:0] f);
    int ia, ib, n, t, sa;
    logic c;
    ia = int'(a); ib = int'(b); n = ib % 16; c = 1'b0; t = 0;
    case (op)
      4'd0, 4'd1: begin t = ia + ib + int'(op == 4'd1); c = (t > 65535); end
      4'd2, 4'd3: begin t = ia - ib - int'(op == 4'd3); c = (t < 0); end
      4'd4: t = ia & ib;
      4'd5: t = ia | ib;
      4'd6: t = ia ^ ib;
      4'd7: t = 65535 - ia;
      4'd8: begin t = ia * (2 ** n); c = (n != 0) && (((ia / (2 ** (16 - n))) % 2) == 1); end
      4'd9, 4'd10: begin
        sa = (op == 4'd10 && ia >= 32768) ? ia - 65536 : ia;
        t  = sa >>> n;
        c  = (n != 0) && (((ia / (2 ** (n - 1))) % 2) == 1);
      end
      default: t = 0;
    endcase
    t = t & 32'hFFFF;
    r = t[15:0];
    if (op > 4'd10) f = 3'b010;
    else            f = {r[15], (r == 16'h0), c};
  endfunction

  task automatic drive(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    bus.opcode = op; bus.operandA = a; bus.operandB = b;
  endtask

  initial begin
    logic [15:0] mr;
    logic [2:0]  mf;
    checks = 0; errors = 0;
    reset_n = 1'b0; bus.load = 1'b0;
    drive(A_ADD, 16'h0, 16'h0);

    vecs.push_back('{A_ADD,    16'hFFFF, 16'h0001, 16'h0000, 3'b011});
    vecs.push_back('{A_ADDPLS, 16'h0001, 16'h0002, 16'h0004, 3'b000});
    vecs.push_back('{A_SUB,    16'h0003, 16'h0005, 16'hFFFE, 3'b101});
    vecs.push_back('{A_SUBMNS, 16'h0005, 16'h0004, 16'h0000, 3'b010});
    vecs.push_back('{A_SUBMNS, 16'h0000, 16'hFFFF, 16'h0000, 3'b011});
    vecs.push_back('{A_AND,    16'hF0F0, 16'h0FF0, 16'h00F0, 3'b000});
    vecs.push_back('{A_OR,     16'h0000, 16'h0042, 16'h0042, 3'b000});
    vecs.push_back('{A_XOR,    16'hAAAA, 16'hAAAA, 16'h0000, 3'b010});
    vecs.push_back('{A_NOT,    16'h00FF, 16'h1234, 16'hFF00, 3'b100});
    vecs.push_back('{A_SL,     16'h8001, 16'h0001, 16'h0002, 3'b001});
    vecs.push_back('{A_SRL,    16'h8001, 16'h0001, 16'h4000, 3'b001});
    vecs.push_back('{A_SRA,    16'h8001, 16'h0004, 16'hF800, 3'b100});
    vecs.push_back('{A_SL,     16'h8001, 16'h0000, 16'h8001, 3'b100});
    vecs.push_back('{A_SL,     16'h8001, 16'h0011, 16'h0002, 3'b001});
    vecs.push_back('{A_SL,     16'h0003, 16'h000F, 16'h8000, 3'b101});
    vecs.push_back('{A_SRL,    16'h8000, 16'hFFFF, 16'h0001, 3'b000});
    vecs.push_back('{A_SRA,    16'h8000, 16'h000F, 16'hFFFF, 3'b100});
    vecs.push_back('{4'd13,    16'h1234, 16'h5678, 16'h0000, 3'b010});
    vecs.push_back('{4'd11,    16'hFFFF, 16'hFFFF, 16'h0000, 3'b010});

    #1;
    chk("reset ALUo_q", 32'(bus.ALUo_q), 32'h0);
    chk("reset flags_q", 32'(bus.flags_q), 32'h0);

    foreach (vecs[i]) begin
      drive(vecs[i].op, vecs[i].a, vecs[i].b);
      #1;
      chk($sformatf("vec%0d res", i), 32'(bus.ALUo), 32'(vecs[i].res));
      chk($sformatf("vec%0d flags", i), 32'(bus.flags), 32'(vecs[i].flg));
    end

    for (int i = 0; i < 400; i++) begin
      drive(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom));
      #1;
      model(bus.opcode, bus.operandA, bus.operandB, mr, mf);
      chk($sformatf("rand op%0d a=%h b=%h res", bus.opcode, bus.operandA, bus.operandB),
          32'(bus.ALUo), 32'(mr));
      chk($sformatf("rand op%0d a=%h b=%h flags", bus.opcode, bus.operandA, bus.operandB),
          32'(bus.flags), 32'(mf));
    end

    // Registered path sequences.
    @(negedge clock); reset_n = 1'b1;
    @(posedge clock); #1;
    chk("post-release idle ALUo_q", 32'(bus.ALUo_q), 32'h0);

    @(negedge clock); drive(A_ADD, 16'h1234, 16'h0001); bus.load = 1'b1;
    @(posedge clock); #1;
    chk("load ALUo_q", 32'(bus.ALUo_q), 32'h1235);
    chk("load flags_q", 32'(bus.flags_q), 32'h0);

    @(negedge clock); drive(A_SUB, 16'h0000, 16'h0001); bus.load = 1'b0;
    @(posedge clock); #1;
    chk("hold ALUo_q", 32'(bus.ALUo_q), 32'h1235);
    chk("hold flags_q", 32'(bus.flags_q), 32'h0);
    chk("hold comb ALUo", 32'(bus.ALUo), 32'hFFFF);

    @(negedge clock); bus.load = 1'b1;
    @(posedge clock); #1;
    chk("load2 ALUo_q", 32'(bus.ALUo_q), 32'hFFFF);
    chk("load2 flags_q", 32'(bus.flags_q), 32'h5);

    #2 reset_n = 1'b0;
    #1;
    chk("async reset ALUo_q", 32'(bus.ALUo_q), 32'h0);
    chk("async reset flags_q", 32'(bus.flags_q), 32'h0);
    @(posedge clock); #1;
    chk("reset over load ALUo_q", 32'(bus.ALUo_q), 32'h0);

    @(negedge clock); reset_n = 1'b1;
    #1;
    chk("release no capture", 32'(bus.ALUo_q), 32'h0);
    @(posedge clock); #1;
    chk("release then capture ALUo_q", 32'(bus.ALUo_q), 32'hFFFF);
    chk("release then capture flags_q", 32'(bus.flags_q), 32'h5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
